// File: rtl/jk_pkg.sv
// Shared JK cell input encodings and the load clamp helper used by the modulo counter.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_CLEAR  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Saturate an out-of-range load value to the top of the count range.
  function automatic int unsigned clamp_value(input int unsigned value,
                                              input int unsigned modulus);
    return (value >= modulus) ? modulus - 1 : value;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK storage element with asynchronous active-high reset and preset (reset wins).
module jk_cell
  import jk_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic preset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_d, q_q;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      JK_HOLD:   q_d = q_q;
      JK_CLEAR:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset or posedge preset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else if (preset) begin
      q_q <= 1'b1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from per-bit JK cells, with clamped synchronous load,
// combinational terminal-count flag and a registered one-cycle wrap pulse.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             preset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             terminal,
  output logic             wrapped
);

  // One extra bit keeps MODULUS = 2^WIDTH representable.
  localparam logic [WIDTH:0]   MaxExt        = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] PresetPattern = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   q_ext, count_ext;
  logic [WIDTH-1:0] q_next, load_clamped;
  logic             wrap;
  logic             wrapped_d, wrapped_q;

  always_comb begin
    q_ext        = {1'b0, q};
    count_ext    = q_ext;
    wrap         = 1'b0;
    load_clamped = WIDTH'(clamp_value(32'(load_value), MODULUS));
    if (up_down) begin
      if (q_ext == MaxExt) begin
        count_ext = '0;
        wrap      = 1'b1;
      end else begin
        count_ext = q_ext + (WIDTH + 1)'(1);
      end
    end else begin
      if (q_ext == '0) begin
        count_ext = MaxExt;
        wrap      = 1'b1;
      end else begin
        count_ext = q_ext - (WIDTH + 1)'(1);
      end
    end

    if (load) begin
      q_next    = load_clamped;
      wrapped_d = 1'b0;
    end else if (enable) begin
      q_next    = count_ext[WIDTH-1:0];
      wrapped_d = wrap;
    end else begin
      q_next    = q;
      wrapped_d = 1'b0;
    end
  end

  assign terminal = enable & (up_down ? (q_ext == MaxExt) : (q_ext == '0));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic cell_reset, cell_preset, j, k;

    // Preset loads MODULUS-1: bits that are 0 in that value are cleared instead.
    assign cell_reset  = reset | (preset & ~PresetPattern[i]);
    assign cell_preset = ~reset & preset & PresetPattern[i];
    assign j           = q_next[i] & ~q[i];
    assign k           = ~q_next[i] & q[i];

    jk_cell u_cell (
      .clock  (clock),
      .reset  (cell_reset),
      .preset (cell_preset),
      .j      (j),
      .k      (k),
      .q      (q[i])
    );
  end

  always_ff @(posedge clock or posedge reset or posedge preset) begin
    if (reset || preset) begin
      wrapped_q <= 1'b0;
    end else begin
      wrapped_q <= wrapped_d;
    end
  end

  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter in three configurations: 4/10, 3/8 and 1/2.
module tb_jk_mod_counter;

  logic clock = 1'b0;
  logic reset, preset;

  logic       a_en, a_ud, a_ld, a_term, a_wr;
  logic [3:0] a_lv, a_q;
  logic       b_en, b_ud, b_ld, b_term, b_wr;
  logic [2:0] b_lv, b_q;
  logic       c_en, c_ud, c_ld, c_term, c_wr;
  logic [0:0] c_lv, c_q;

  always #5 clock = ~clock;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
    .clock(clock), .reset(reset), .preset(preset), .enable(a_en), .up_down(a_ud),
    .load(a_ld), .load_value(a_lv), .q(a_q), .terminal(a_term), .wrapped(a_wr)
  );

  jk_mod_counter #(.WIDTH(3), .MODULUS(8)) u_dut_b (
    .clock(clock), .reset(reset), .preset(preset), .enable(b_en), .up_down(b_ud),
    .load(b_ld), .load_value(b_lv), .q(b_q), .terminal(b_term), .wrapped(b_wr)
  );

  jk_mod_counter #(.WIDTH(1), .MODULUS(2)) u_dut_c (
    .clock(clock), .reset(reset), .preset(preset), .enable(c_en), .up_down(c_ud),
    .load(c_ld), .load_value(c_lv), .q(c_q), .terminal(c_term), .wrapped(c_wr)
  );

  typedef struct {
    int    idx;
    int    q;
    logic  w;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mdl[3];
  int   modu[3] = '{10, 8, 2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_q(input int idx);
    case (idx)
      0:       return 32'(a_q);
      1:       return 32'(b_q);
      default: return 32'(c_q);
    endcase
  endfunction

  function automatic logic [31:0] get_wr(input int idx);
    case (idx)
      0:       return 32'(a_wr);
      1:       return 32'(b_wr);
      default: return 32'(c_wr);
    endcase
  endfunction

  function automatic logic [31:0] get_term(input int idx);
    case (idx)
      0:       return 32'(a_term);
      1:       return 32'(b_term);
      default: return 32'(c_term);
    endcase
  endfunction

  task automatic set_in(input int idx, input logic en, input logic ud, input logic ld,
                        input int lv);
    a_en = 1'b0; a_ud = 1'b1; a_ld = 1'b0; a_lv = '0;
    b_en = 1'b0; b_ud = 1'b1; b_ld = 1'b0; b_lv = '0;
    c_en = 1'b0; c_ud = 1'b1; c_ld = 1'b0; c_lv = '0;
    case (idx)
      0: begin a_en = en; a_ud = ud; a_ld = ld; a_lv = 4'(lv); end
      1: begin b_en = en; b_ud = ud; b_ld = ld; b_lv = 3'(lv); end
      default: begin c_en = en; c_ud = ud; c_ld = ld; c_lv = 1'(lv); end
    endcase
  endtask

  // Drive one cycle on a single DUT, predict its outcome, then compare after the edge.
  task automatic drive_edge(input int idx, input logic en, input logic ud, input logic ld,
                            input int lv, input string tag);
    exp_t e;
    int   mx;
    int   nq;
    logic w;
    mx = modu[idx] - 1;
    set_in(idx, en, ud, ld, lv);
    #1;
    check({tag, ":terminal"}, get_term(idx),
          32'(en && (ud ? (mdl[idx] == mx) : (mdl[idx] == 0))));
    w = 1'b0;
    if (ld) begin
      nq = (lv > mx) ? mx : lv;
    end else if (en) begin
      if (ud) begin
        if (mdl[idx] == mx) begin nq = 0; w = 1'b1; end
        else nq = mdl[idx] + 1;
      end else begin
        if (mdl[idx] == 0) begin nq = mx; w = 1'b1; end
        else nq = mdl[idx] - 1;
      end
    end else begin
      nq = mdl[idx];
    end
    e.idx = idx; e.q = nq; e.w = w; e.tag = tag;
    sb.push_back(e);
    mdl[idx] = nq;
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.tag, ":q"}, get_q(e.idx), 32'(e.q));
    check({e.tag, ":wrapped"}, get_wr(e.idx), 32'(e.w));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    preset = 1'b0;
    set_in(0, 1'b0, 1'b1, 1'b0, 0);
    #2;
    check("reset_a_q", 32'(a_q), 32'd0);
    check("reset_a_wrapped", 32'(a_wr), 32'd0);
    check("reset_b_q", 32'(b_q), 32'd0);
    check("reset_c_q", 32'(c_q), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mdl = '{0, 0, 0};

    for (int i = 0; i < 12; i++) drive_edge(0, 1'b1, 1'b1, 1'b0, 0, "up");

    drive_edge(0, 1'b0, 1'b1, 1'b1, 0, "load0");
    for (int i = 0; i < 3; i++) drive_edge(0, 1'b1, 1'b0, 1'b0, 0, "down");

    drive_edge(0, 1'b0, 1'b1, 1'b1, 6, "load6");
    drive_edge(0, 1'b1, 1'b1, 1'b1, 13, "load13_clamp");

    // Preset mid-count, then reset on top of it; clock edges must be ignored throughout.
    set_in(0, 1'b1, 1'b1, 1'b0, 0);
    #2;
    preset = 1'b1;
    #1;
    check("preset_a_q", 32'(a_q), 32'd9);
    check("preset_a_wrapped", 32'(a_wr), 32'd0);
    check("preset_b_q", 32'(b_q), 32'd7);
    check("preset_c_q", 32'(c_q), 32'd1);
    @(posedge clock);
    #1;
    check("preset_hold_a_q", 32'(a_q), 32'd9);
    #2;
    reset = 1'b1;
    #1;
    check("reset_over_preset_q", 32'(a_q), 32'd0);
    @(posedge clock);
    #1;
    check("reset_hold_q", 32'(a_q), 32'd0);
    @(negedge clock);
    preset = 1'b0;
    reset  = 1'b0;
    mdl = '{0, 0, 0};

    // Reset right after a wrap must clear the wrap pulse immediately.
    drive_edge(0, 1'b0, 1'b1, 1'b1, 9, "load9");
    drive_edge(0, 1'b1, 1'b1, 1'b0, 0, "wrap_before_reset");
    #1;
    reset = 1'b1;
    #1;
    check("reset_mid_q", 32'(a_q), 32'd0);
    check("reset_mid_wrapped", 32'(a_wr), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    mdl[0] = 0;

    drive_edge(0, 1'b0, 1'b1, 1'b1, 8, "load8");
    for (int i = 0; i < 5; i++) drive_edge(0, (i % 2) == 0, 1'b1, 1'b0, 0, "en_toggle");

    drive_edge(1, 1'b0, 1'b1, 1'b1, 7, "b_load7");
    for (int i = 0; i < 2; i++) drive_edge(1, 1'b1, 1'b1, 1'b0, 0, "b_up");

    for (int i = 0; i < 4; i++) drive_edge(2, 1'b1, 1'b1, 1'b0, 0, "c_up");
    drive_edge(2, 1'b1, 1'b0, 1'b0, 0, "c_down");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Parametrised synchronous modulo-N up/down counter built from per-bit JK storage cells. It replaces single-bit JK flip-flops wherever the design needs a multi-bit counter, for example digit counters, timers and sequence indices. It adds synchronous load, count enable, direction control, modulo wrap and a wrap indication on top of asynchronous reset and preset.

## Interface
- WIDTH, default 4: counter width in bits; legal range 1..16.
- MODULUS, default 10: count range is 0..MODULUS-1; legal range 2..2^WIDTH.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces the count to 0.
- preset  in  1  asynchronous, active-high; forces the count to MODULUS-1; reset dominates.
- enable  in  1  count enable, sampled on the clock edge.
- up_down  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value loaded when load=1.
- q  out  WIDTH  current count (registered).
- terminal  out  1  combinational; 1 when enable=1 and q is at the wrap point for the current direction.
- wrapped  out  1  registered; 1 for exactly one cycle after an edge on which the counter wrapped.

## Operation
- Reset values: q=0, wrapped=0. Preset values: q=MODULUS-1, wrapped=0.
- reset and preset act immediately, independent of clock. With both high, reset wins. While either is high, clock edges are ignored.
- Synchronous priority on each rising edge: load, then enable, then hold.
- load=1: q takes load_value. If load_value ≥ MODULUS, q takes MODULUS-1 (clamp). load ignores enable. wrapped=0.
- load=0, enable=1, up_down=1: q=q+1, except q=MODULUS-1 gives q=0 and wrapped=1.
- load=0, enable=1, up_down=0: q=q-1, except q=0 gives q=MODULUS-1 and wrapped=1.
- load=0, enable=0: q holds; wrapped=0.
- terminal = enable & (up_down ? q==MODULUS-1 : q==0). It is independent of load.
- Next-state arithmetic is done in WIDTH+1 bits, so MODULUS=2^WIDTH wraps without overflow.
- Per-bit storage follows JK semantics. For each bit, J = next & ~q and K = ~next & q. The cell is J=K=0 hold, 01 clear, 10 set, 11 toggle. The JK inputs never leave an intermediate value on q.

## Timing
- Count, load and hold take effect on the first rising edge where the condition is sampled; latency is 1 cycle.
- wrapped asserts on the same edge that produces the wrapped q value and deasserts on the next edge unless another wrap occurs.
- Asynchronous release: the first counting edge is the first rising edge after reset and preset are both low. Deassertion is synchronised by the user.
- Reset during a count: q=0 immediately and wrapped=0 immediately; no partial update.
- Changing direction at the boundary: with q=0, up_down=0 and enable=1, the next edge gives q=MODULUS-1 and wrapped=1.

## Structure
- Shared package jk_pkg holds:
  - the JK input encodings JK_HOLD=2'b00, JK_CLEAR=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11;
  - the clamp helper function.
- Sub-module jk_cell: a single-bit JK storage element with asynchronous reset and asynchronous preset. The counter instantiates WIDTH of them through a generate loop. The per-bit preset/reset pattern is derived from MODULUS-1.
- The counter itself contains next-state logic, clamp, terminal and the wrapped register.

## Test plan
- Apply reset, release it, then 12 enabled up edges with WIDTH=4 and MODULUS=10 -> q runs 1..9, 0, 1, 2; wrapped is 1 only on the cycle after q becomes 0.
- Start from q=0 and apply 3 enabled down edges -> q = 9, 8, 7; terminal=1 before the first edge; wrapped is pulsed once.
- Load 6, then load 13 -> q=6, then q=9 (clamped); loading with enable=0 still takes effect; wrapped stays 0.
- Assert preset mid-count, then reset while preset is still high -> q=9 immediately, then q=0; clock edges are ignored while either is asserted.
- Toggle enable every other edge while counting up from 8 -> q = 9, 9, 0, 0, 1; terminal is 1 only when enable=1 and q=9.
- Run WIDTH=3, MODULUS=8 up from 7, then WIDTH=1, MODULUS=2 -> clean wrap to 0, and a 0,1,0,1 toggle pattern with wrapped set every second edge.
